// File: rtl/step_pkg.sv
// step_pkg
//   Shared definitions for the step button controller: FSM state encoding,
//   direction codes and counter-width helpers.
//   No ports (package).
package step_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Bits needed to hold every value 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_button_ctrl_debounce.sv
// btn_debounce
//   Two-flop synchroniser followed by a debounce filter for one raw button.
//   The debounced level only changes after the synchronised input has
//   disagreed with it for DEB_CYCLES+1 consecutive samples; any agreeing
//   sample restarts the count, so short glitches are dropped.
// Ports
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw asynchronous button, 1 = pressed
//   level  out 1  debounced button level
module btn_debounce
  import step_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_button_ctrl.sv
// step_button_ctrl
//   Turns two raw push-buttons into a direction level and a step strobe for
//   blind_cycler. One step per press, auto-repeat while held, no steps while
//   both buttons are down. dir only changes in IDLE, so it is stable for a
//   full cycle before nxt rises and for the whole time nxt is high.
// Ports
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   btn_up  in  1  raw button, 1 = pressed, step up
//   btn_dn  in  1  raw button, 1 = pressed, step down
//   nxt     out 1  registered step strobe, PULSE_W cycles per step
//   dir     out 1  registered direction, 0 = up, 1 = down
//   active  out 1  registered, 1 whenever the FSM is not IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no button accepted; dir latched on exit to S_SETUP
// S_SETUP | one cycle with dir settled and nxt low
// S_PULSE | nxt high for PULSE_W cycles; repeat timer loaded on entry
// S_WAIT  | nxt low; watch for release, second button or repeat expiry
// S_LOCK  | both buttons seen; wait until both are released
module step_button_ctrl
  import step_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_PERIOD = 16,
  parameter int PULSE_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  output logic nxt,
  output logic dir,
  output logic active
);

  localparam int TW = cnt_width(max_int(REP_DELAY, REP_PERIOD));
  localparam int PW = cnt_width(PULSE_W);

  logic          up_lvl;
  logic          dn_lvl;
  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] rep_cnt;
  logic [PW-1:0] pls_cnt;
  logic          held;
  logic          other;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_up),
    .level (up_lvl)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_dn),
    .level (dn_lvl)
  );

  // The button that started the current run versus the opposite one.
  assign held  = (dir == DIR_DN) ? dn_lvl : up_lvl;
  assign other = (dir == DIR_DN) ? up_lvl : dn_lvl;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (up_lvl && dn_lvl) begin
          state_nx = S_LOCK;
        end else if (up_lvl ^ dn_lvl) begin
          state_nx = S_SETUP;
        end
      end
      S_SETUP: state_nx = S_PULSE;
      S_PULSE: begin
        if (pls_cnt == '0) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // Releasing the held button wins over everything, so a reversal
        // (release one, press the other) always goes back through IDLE.
        if (!held) begin
          state_nx = S_IDLE;
        end else if (other) begin
          state_nx = S_LOCK;
        end else if (rep_cnt == '0) begin
          state_nx = S_PULSE;
        end
      end
      S_LOCK: begin
        if (!up_lvl && !dn_lvl) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      nxt     <= 1'b0;
      dir     <= DIR_UP;
      active  <= 1'b0;
      rep_cnt <= '0;
      pls_cnt <= '0;
    end else begin
      state  <= state_nx;
      nxt    <= (state_nx == S_PULSE);
      active <= (state_nx != S_IDLE);

      if (state == S_IDLE && state_nx == S_SETUP) begin
        dir <= dn_lvl ? DIR_DN : DIR_UP;
      end

      // Timers count down to a terminal count of zero and then hold there.
      // Loading with N-1 at pulse entry makes the next rise land exactly
      // N cycles after this one.
      if (state != S_PULSE && state_nx == S_PULSE) begin
        pls_cnt <= PW'(PULSE_W - 1);
        rep_cnt <= (state == S_SETUP) ? TW'(REP_DELAY - 1) : TW'(REP_PERIOD - 1);
      end else begin
        if (state == S_PULSE && pls_cnt != '0) begin
          pls_cnt <= pls_cnt - 1'b1;
        end
        if (rep_cnt != '0) begin
          rep_cnt <= rep_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_button_ctrl.sv
// tb_step_button_ctrl
//   Self-checking bench for step_button_ctrl with DEB_CYCLES=4, REP_DELAY=20,
//   REP_PERIOD=8, PULSE_W=2. Inputs change on the falling edge, outputs are
//   sampled on the falling edge. Every cycle is compared against an
//   edge-indexed behavioural model; a vector table and a few hand-written
//   sequences add fixed expectations on top.
module tb_step_button_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int PW  = 2;
  localparam int HN  = 64;
  localparam int WIN = 100;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic nxt;
  logic dir;
  logic active;

  always #5 clk = ~clk;

  step_button_ctrl #(
    .DEB_CYCLES (DEB),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP),
    .PULSE_W    (PW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .nxt    (nxt),
    .dir    (dir),
    .active (active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edge e is the e-th rising edge after reset release. The synchronised
  // value seen at edge e is the raw sample taken at edge e-2.
  int m_e;
  bit h_up[HN];
  bit h_dn[HN];
  int flip_up, flip_dn;
  bit deb_up, deb_dn;
  int mode;               // 0 idle, 1 stepping, 2 locked
  bit m_dir;
  int next_rise, last_rise, n_rises;
  bit m_nxt;

  function automatic bit hist(input bit sel, input int idx);
    if (idx < 0) return 1'b0;
    return sel ? h_dn[idx % HN] : h_up[idx % HN];
  endfunction

  // Level accepted when the DEB+1 synced samples at edges e-DEB..e, all taken
  // after the previous change, disagree with it.
  function automatic bit run_differs(input bit sel, input bit lvl, input int last_flip);
    if (m_e - DEB <= last_flip) return 1'b0;
    for (int j = m_e - DEB; j <= m_e; j++) begin
      if (hist(sel, j - 2) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_e = 0;
    flip_up = -1;
    flip_dn = -1;
    deb_up = 1'b0;
    deb_dn = 1'b0;
    mode = 0;
    m_dir = 1'b0;
    next_rise = -1;
    last_rise = -1000;
    n_rises = 0;
    m_nxt = 1'b0;
    for (int i = 0; i < HN; i++) begin
      h_up[i] = 1'b0;
      h_dn[i] = 1'b0;
    end
  endtask

  task automatic take_step();
    last_rise = m_e;
    n_rises++;
    next_rise = m_e + ((n_rises == 1) ? RD : RP);
  endtask

  task automatic model_edge(input bit up_raw, input bit dn_raw);
    bit held, other;
    case (mode)
      0: begin
        if (deb_up && deb_dn) begin
          mode = 2;
        end else if (deb_up || deb_dn) begin
          mode = 1;
          m_dir = deb_dn;
          next_rise = m_e + 1;
          n_rises = 0;
        end
      end
      1: begin
        held  = m_dir ? deb_dn : deb_up;
        other = m_dir ? deb_up : deb_dn;
        if (n_rises > 0 && m_e > last_rise + PW) begin
          if (!held) mode = 0;
          else if (other) mode = 2;
          else if (m_e == next_rise) take_step();
        end else if (n_rises == 0 && m_e == next_rise) begin
          take_step();
        end
      end
      default: begin
        if (!deb_up && !deb_dn) mode = 0;
      end
    endcase
    m_nxt = (m_e - last_rise) < PW;
    h_up[m_e % HN] = up_raw;
    h_dn[m_e % HN] = dn_raw;
    if (run_differs(1'b0, deb_up, flip_up)) begin
      deb_up = !deb_up;
      flip_up = m_e;
    end
    if (run_differs(1'b1, deb_dn, flip_dn)) begin
      deb_dn = !deb_dn;
      flip_dn = m_e;
    end
    m_e++;
  endtask

  // ---------------- observation / protocol tracking ----------------
  bit p_nxt, p_dir, rise_dir, first_dir;
  int width, rise_cnt, first_rise, last_rise_obs, base;

  task automatic track_start();
    base = m_e;
    rise_cnt = 0;
    first_rise = -1;
    last_rise_obs = -1;
    first_dir = 1'b0;
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample at
  // the next falling edge.
  task automatic cyc(input bit up, input bit dn);
    btn_up = up;
    btn_dn = dn;
    @(posedge clk);
    model_edge(up, dn);
    @(negedge clk);
    check("nxt", 32'(nxt), 32'(m_nxt));
    check("dir", 32'(dir), 32'(m_dir));
    check("active", 32'(active), 32'(mode != 0));
    if (nxt === 1'b1 && !p_nxt) begin
      check("dir_before_rise", 32'(dir), 32'(p_dir));
      rise_dir = dir;
      width = 1;
      rise_cnt++;
      last_rise_obs = m_e - 1 - base;
      if (first_rise < 0) begin
        first_rise = last_rise_obs;
        first_dir = dir;
      end
    end else if (nxt === 1'b1) begin
      width++;
    end else if (p_nxt) begin
      check("nxt_width", 32'(width), 32'(PW));
      check("dir_at_fall", 32'(dir), 32'(rise_dir));
    end
    p_nxt = (nxt === 1'b1);
    p_dir = dir;
  endtask

  task automatic do_reset();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst_n = 1'b0;
    model_reset();
    p_nxt = 1'b0;
    p_dir = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int up_len;
    int dn_len;
    int dn_start;
    bit bounce;
    int exp_rises;
    int exp_first;
    bit exp_dir;
  } vec_t;

  vec_t vt[8];
  bit   su, sd, bnc;
  int   r, len;

  initial begin
    vt[0] = '{12,  0, 0, 1'b0, 1,  8, 1'b0};  // single press
    vt[1] = '{ 0, 60, 0, 1'b0, 6,  8, 1'b1};  // held down: 8,28,36,44,52,60
    vt[2] = '{ 0,  0, 0, 1'b1, 0, -1, 1'b0};  // bouncing up button
    vt[3] = '{ 4,  0, 0, 1'b0, 0, -1, 1'b0};  // one sample too short
    vt[4] = '{ 5,  0, 0, 1'b0, 1,  8, 1'b0};  // just long enough
    vt[5] = '{ 0, 21, 0, 1'b0, 1,  8, 1'b1};  // released just before repeat
    vt[6] = '{ 0, 22, 0, 1'b0, 2,  8, 1'b1};  // released just after repeat
    vt[7] = '{30, 30, 0, 1'b0, 0, -1, 1'b0};  // simultaneous press -> lock

    do_reset();
    @(negedge clk);
    check("reset_nxt", 32'(nxt), 32'd0);
    check("reset_dir", 32'(dir), 32'd0);
    check("reset_active", 32'(active), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      track_start();
      for (int t = 0; t < WIN; t++) begin
        su = vt[i].bounce ? (t < 40 && (t % 4) != 3) : (t < vt[i].up_len);
        sd = (t >= vt[i].dn_start) && (t < vt[i].dn_start + vt[i].dn_len);
        cyc(su, sd);
      end
      check($sformatf("vec%0d_rises", i), 32'(rise_cnt), 32'(vt[i].exp_rises));
      check($sformatf("vec%0d_first", i), 32'(first_rise), 32'(vt[i].exp_first));
      if (vt[i].exp_rises > 0)
        check($sformatf("vec%0d_dir", i), 32'(first_dir), 32'(vt[i].exp_dir));
      check($sformatf("vec%0d_idle", i), 32'(active), 32'd0);
    end

    // dir settles at edge 7, one cycle before the first rise at edge 8.
    do_reset();
    track_start();
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, 1'b1);
      if (t == 6) check("dn_dir_e6", 32'(dir), 32'd0);
      if (t == 7) begin
        check("dn_dir_e7", 32'(dir), 32'd1);
        check("dn_active_e7", 32'(active), 32'd1);
        check("dn_nxt_e7", 32'(nxt), 32'd0);
      end
      if (t == 8) check("dn_nxt_e8", 32'(nxt), 32'd1);
    end
    repeat (20) cyc(1'b0, 1'b0);

    // Second button during a held run: the pulse at 36 is already decided,
    // then LOCK until both are released; a fresh press steps down once.
    do_reset();
    track_start();
    for (int t = 0; t < 80; t++) cyc(1'b1, t >= 30);
    check("lock_rises", 32'(rise_cnt), 32'd3);
    check("lock_last_rise", 32'(last_rise_obs), 32'd36);
    check("lock_active", 32'(active), 32'd1);
    check("lock_nxt", 32'(nxt), 32'd0);
    repeat (20) cyc(1'b0, 1'b0);
    check("lock_exit", 32'(active), 32'd0);
    track_start();
    repeat (15) cyc(1'b0, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);
    check("post_lock_rises", 32'(rise_cnt), 32'd1);
    check("post_lock_first", 32'(first_rise), 32'd8);
    check("post_lock_dir", 32'(first_dir), 32'd1);

    // Reset while nxt is high: outputs clear immediately, nothing resumes.
    do_reset();
    track_start();
    for (int t = 0; t < 20 && nxt !== 1'b1; t++) cyc(1'b0, 1'b1);
    check("rst_pulse_seen", 32'(nxt), 32'd1);
    check("rst_pre_dir", 32'(dir), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_nxt", 32'(nxt), 32'd0);
    check("rst_async_dir", 32'(dir), 32'd0);
    check("rst_async_active", 32'(active), 32'd0);
    btn_dn = 1'b0;
    model_reset();
    p_nxt = 1'b0;
    p_dir = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_nxt", 32'(nxt), 32'd0);
      check("rst_hold_active", 32'(active), 32'd0);
    end
    rst_n = 1'b1;
    track_start();
    repeat (15) cyc(1'b0, 1'b0);
    check("rst_no_resume", 32'(rise_cnt), 32'd0);

    // Random segments against the model.
    do_reset();
    for (int s = 0; s < 120; s++) begin
      r = $urandom_range(0, 19);
      if (r == 0) do_reset();
      r = $urandom_range(0, 9);
      su = (r >= 3 && r <= 5) || r == 9;
      sd = (r >= 6 && r <= 8) || r == 9;
      bnc = ($urandom_range(0, 6) == 0);
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        if (bnc) cyc(su & ($urandom_range(0, 2) != 0), sd & ($urandom_range(0, 2) != 0));
        else cyc(su, sd);
      end
    end
    repeat (40) cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
